// File: rtl/cla_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
// cla_seq_adder_ctrl : sequential add/sub built from one 3-bit CLA slice
// Revision: 1.0
// ============================================================================

module cla_seq_adder_ctrl #(
  parameter int SLICES = 4,
  localparam int W = 3 * SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [2:0] slice_a, slice_b, slice_g, slice_p;
  logic [3:0] slice_s;
  logic       c1, c2, c3;

  // 3-bit carry-lookahead slice; slice_s[3] is the chunk carry-out.
  always_comb begin
    slice_a = opa_q[3*k_q +: 3];
    slice_b = opb_q[3*k_q +: 3];
    slice_g = slice_a & slice_b;
    slice_p = slice_a ^ slice_b;
    c1 = slice_g[0] | (slice_p[0] & carry_q);
    c2 = slice_g[1] | (slice_p[1] & slice_g[0]) | (slice_p[1] & slice_p[0] & carry_q);
    c3 = slice_g[2] | (slice_p[2] & slice_g[1]) | (slice_p[2] & slice_p[1] & slice_g[0])
       | (slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
    slice_s = {c3, slice_p ^ {c2, c1, carry_q}};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        busy_d = 1'b1;
        sum_d[3*k_q +: 3] = slice_s[2:0];
        carry_d = slice_s[3];
        if (k_q == K_LAST) begin
          cout_d  = slice_s[3];
          // Operands share a sign but the result's sign differs.
          ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (slice_s[2] != opa_q[W-1]);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cla_seq_adder_ctrl : directed self-checking bench for cla_seq_adder_ctrl
// Revision: 1.0
// ============================================================================

module tb_cla_seq_adder_ctrl;

  localparam int SLICES = 4;
  localparam int W = 3 * SLICES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;

  cla_seq_adder_ctrl #(.SLICES(SLICES)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (sum !== 12'h000) begin failures++; $display("FAIL reset_sum: got %h want 000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b want 0", cout); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    step();
  endtask

  // Issues one request from IDLE and checks busy/done timing plus the result.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vcin, input logic vsub, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
    step();
    start = 1'b0;
    a = ~va; b = va ^ vb; cin = ~vcin; sub = ~vsub;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL %s_accept: busy=%b done=%b want busy=1 done=0", name, busy, done);
    end
    for (int i = 1; i <= SLICES; i++) begin
      step();
      if (i < SLICES) begin
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
          failures++; $display("FAIL %s_busy%0d: busy=%b done=%b want busy=1 done=0", name, i, busy, done);
        end
      end else begin
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin
          failures++; $display("FAIL %s_done: busy=%b done=%b want busy=0 done=1", name, busy, done);
        end
        checks++; if (sum !== exp_sum) begin
          failures++; $display("FAIL %s_sum: got %h want %h", name, sum, exp_sum);
        end
        checks++; if (cout !== exp_cout) begin
          failures++; $display("FAIL %s_cout: got %b want %b", name, cout, exp_cout);
        end
        checks++; if (ovf !== exp_ovf) begin
          failures++; $display("FAIL %s_ovf: got %b want %b", name, ovf, exp_ovf);
        end
      end
    end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s_pulse: busy=%b done=%b want both 0", name, busy, done);
    end
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
  endtask

  task automatic test_add();
    run_op("add_basic", 12'h123, 12'h456, 1'b0, 1'b0, 12'h579, 1'b0, 1'b0);
    step();
    step();
    checks++; if (sum !== 12'h579 || done !== 1'b0) begin
      failures++; $display("FAIL idle_hold: sum=%h done=%b want sum=579 done=0", sum, done);
    end
    run_op("add_ripple", 12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    run_op("add_cin", 12'h0FF, 12'h001, 1'b1, 1'b0, 12'h101, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    run_op("sub_borrow", 12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0);
    run_op("sub_noborrow", 12'h007, 12'h005, 1'b1, 1'b1, 12'h002, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    run_op("ovf_add", 12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
    run_op("ovf_sub", 12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);
  endtask

  // start held high, operands changing every cycle; only edges 0, 5 and 10 accept.
  task automatic test_back_to_back();
    logic [W-1:0] exp_tab [3];
    exp_tab[0] = 12'h120;
    exp_tab[1] = 12'h175;
    exp_tab[2] = 12'h1CA;
    start = 1'b1; cin = 1'b0; sub = 1'b0;
    for (int c = 0; c < 15; c++) begin
      a = 12'h100 + 12'(16 * c);
      b = 12'h020 + 12'(c);
      step();
      if ((c % 5) == 4) begin
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
          failures++; $display("FAIL b2b_done_e%0d: busy=%b done=%b want busy=0 done=1", c, busy, done);
        end
        checks++; if (sum !== exp_tab[c / 5]) begin
          failures++; $display("FAIL b2b_sum_e%0d: got %h want %h", c, sum, exp_tab[c / 5]);
        end
      end else begin
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
          failures++; $display("FAIL b2b_busy_e%0d: busy=%b done=%b want busy=1 done=0", c, busy, done);
        end
      end
    end
    start = 1'b0;
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_idle: busy=%b done=%b want both 0", busy, done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    a = 12'h123; b = 12'h456; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || sum !== 12'h000 || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy, done, sum, cout, ovf);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL midrst_quiet%0d: busy=%b done=%b want both 0", i, busy, done);
      end
    end
    run_op("after_rst", 12'h0AB, 12'h055, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
